// File: rtl/llr_loader.sv
// Fetches one codeword of packed LLR words from external memory, last word first,
// and streams them into the decoder's shift-in LLR storage.
module llr_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_code,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_gnt,
  input  logic [63:0]       i_rd_data,
  output logic              o_wen,
  output logic [63:0]       o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  if (RD_LAT != 1) begin : g_lat_check
    $error("llr_loader only supports RD_LAT == 1");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        req_cnt_q, req_cnt_d;
  logic              rd_vld_q;
  logic              wen_q;
  logic [63:0]       data_q;
  logic [7:0]        words;
  logic              grant;

  // Words per codeword: N/8 = 16 << code.
  assign words = 8'd16 << i_code;
  assign grant = (state_q == StFetch) && i_rd_gnt;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StFetch;
          req_cnt_d = words;
          addr_d    = i_base_addr + ADDR_W'(words) - ADDR_W'(1);
        end
      end
      StFetch: begin
        if (i_rd_gnt) begin
          addr_d    = addr_q - ADDR_W'(1);
          req_cnt_d = req_cnt_q - 8'd1;
          if (req_cnt_q == 8'd1) begin
            state_d = StDrain;
          end
        end
      end
      // The last return is in flight on entry; once captured its write follows
      // in the same cycle DONE would start, so DONE lands right after it.
      StDrain: begin
        if (!rd_vld_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      req_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      wen_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_cnt_q <= req_cnt_d;
      rd_vld_q  <= grant;
      wen_q     <= rd_vld_q;
      if (rd_vld_q) begin
        data_q <= i_rd_data;
      end
    end
  end

  assign o_rd_en   = (state_q == StFetch);
  assign o_rd_addr = addr_q;
  assign o_wen     = wen_q;
  assign o_data    = data_q;
  assign o_busy    = (state_q == StFetch) || (state_q == StDrain);
  assign o_done    = (state_q == StDone);

endmodule

// File: tb/tb_llr_loader.sv
// Scoreboard bench for llr_loader: a cycle model predicts handshakes and a queue
// holds the expected write words in issue order.
module tb_llr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  code;
  logic [11:0] base;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        gnt;
  logic [63:0] rd_data;
  logic        wen;
  logic [63:0] data;
  logic        busy;
  logic        done;

  llr_loader #(.ADDR_W(12), .RD_LAT(1)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_code     (code),
    .i_base_addr(base),
    .o_rd_en    (rd_en),
    .o_rd_addr  (rd_addr),
    .i_rd_gnt   (gnt),
    .i_rd_data  (rd_data),
    .o_wen      (wen),
    .o_data     (data),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mem [4096];
  logic [63:0] exp_q [$];
  logic        stall_mode = 1'b0;
  int          gcnt = 0;
  logic        acc_d = 1'b0;
  logic [11:0] addr_d = '0;

  // Reference model state
  int          mcyc = 0;
  int          n_done = 0;
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        p1 = 1'b0;
  logic        p2 = 1'b0;
  logic [11:0] exp_addr = '0;
  int          ld_w = 0, ld_req = 0, ld_wen = 0, ld_start = 0, ld_first = -1;
  logic        ld_stall = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, mcyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (n_done >= target) break;
      @(negedge clk);
    end
    if (n_done < target) check_eq("timeout", 64'd0, 64'd1);
  endtask

  task automatic run_load(input logic [1:0] c, input logic [11:0] b, input logic s);
    int target;
    target = n_done + 1;
    tick();
    start = 1'b1; code = c; base = b; stall_mode = s;
    tick();
    start = 1'b0; code = 2'($urandom); base = 12'($urandom);
    wait_done(target);
    repeat (3) tick();
  endtask

  // Memory and grant driver
  initial begin
    gnt = 1'b1;
    rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      gcnt++;
      gnt = stall_mode ? (gcnt % 3 != 0) : 1'b1;
      rd_data = acc_d ? mem[addr_d] : {$urandom, $urandom};
    end
  end

  // Monitor: compare outputs against the model, then advance the model.
  initial begin
    logic wexp, acc, done_n, start_ok;
    forever begin
      @(negedge clk);
      mcyc++;
      wexp = p2;
      acc  = (m_left != 0) && gnt;
      check_eq("rd_en", 64'(rd_en), 64'(m_left != 0));
      check_eq("busy", 64'(busy), 64'(m_busy));
      check_eq("done", 64'(done), 64'(m_done));
      check_eq("wen", 64'(wen), 64'(wexp));
      if (acc) begin
        check_eq("rd_addr", 64'(rd_addr), 64'(exp_addr));
        exp_q.push_back(mem[exp_addr]);
        exp_addr = exp_addr - 12'd1;
        ld_req++;
      end
      if (rd_en && ld_first < 0) ld_first = mcyc;
      if (wen) begin
        if (exp_q.size() == 0) check_eq("wen_extra", 64'd1, 64'd0);
        else check_eq("data", data, exp_q.pop_front());
        ld_wen++;
      end
      if (m_done) begin
        n_done++;
        check_eq("n_req", 64'(ld_req), 64'(ld_w));
        check_eq("n_wen", 64'(ld_wen), 64'(ld_w));
        check_eq("q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("first_rd", 64'(ld_first - ld_start), 64'd1);
        if (!ld_stall) check_eq("load_time", 64'(mcyc - ld_start), 64'(ld_w + 3));
      end
      acc_d  = rd_en && gnt;
      addr_d = rd_addr;
      if (rst) begin
        m_left = 0; m_busy = 1'b0; m_done = 1'b0; p1 = 1'b0; p2 = 1'b0;
        exp_q.delete();
      end else begin
        done_n   = m_busy && (m_left == 0) && p2 && !p1;
        p2       = p1;
        p1       = acc;
        if (acc) m_left--;
        start_ok = !m_busy && !m_done && start;
        m_busy   = (m_busy && !done_n) || start_ok;
        m_done   = done_n;
        if (start_ok) begin
          m_left   = 16 << code;
          exp_addr = base + 12'(m_left) - 12'd1;
          ld_w = m_left; ld_req = 0; ld_wen = 0; ld_start = mcyc; ld_first = -1;
          ld_stall = stall_mode;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; code = '0; base = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    check_eq("rst_data", data, 64'd0);
    check_eq("rst_addr", 64'(rd_addr), 64'd0);

    run_load(2'd0, 12'h040, 1'b0);
    run_load(2'd3, 12'h100, 1'b1);
    run_load(2'd1, 12'hFF0, 1'b0);

    // Spurious starts at cycles 5, 17 and on o_done (35); fresh start at 36.
    begin
      int target;
      target = n_done + 2;
      tick();
      start = 1'b1; code = 2'd1; base = 12'h200; stall_mode = 1'b0;
      for (int k = 1; k <= 37; k++) begin
        tick();
        start = (k == 5) || (k == 17) || (k == 35) || (k == 36);
        code  = (k == 36) ? 2'd0 : 2'($urandom);
        base  = (k == 36) ? 12'h300 : 12'($urandom);
      end
      start = 1'b0;
      wait_done(target);
      repeat (3) tick();
    end

    // Reset mid-load at cycle 20, restart at cycle 25.
    begin
      int target;
      tick();
      start = 1'b1; code = 2'd2; base = 12'h080; stall_mode = 1'b0;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_data", data, 64'd0);
      check_eq("rst_mid_addr", 64'(rd_addr), 64'd0);
      repeat (4) tick();
      target = n_done + 1;
      start = 1'b1; code = 2'd2; base = 12'h080;
      tick();
      start = 1'b0;
      wait_done(target);
      repeat (3) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
